fpall_issue_ctrl: RTL and testbench

//  Issue/retire controller in front of FPALL_Shared_combine (fixed-latency, no handshake).

---
 rtl/fpall_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fpall_issue_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpall_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpall_issue_ctrl
//   Issue/retire controller in front of the shared fixed-latency FP datapath
//   (FPALL_Shared_combine). The datapath has no handshake. This block gives
//   software-side logic a valid/ready request port and an in-order
//   valid/ready result port, so callers never count cycles themselves.
//
//   Request side : in_valid/in_ready, in_fmt, in_op, in_x, in_y, in_tag
//   Datapath side: fpu_fmt, fpu_opcode, fpu_x, fpu_y (registered), fpu_r
//   Result side  : out_valid/out_ready, out_r, out_tag (FIFO head)
//   Status       : busy (op in flight or result waiting)
//
//   Handshake: a transfer happens on a rising clk edge where valid & ready
//   are both high. A producer holds valid and its payload stable until that
//   transfer. Ready never depends on the valid of the same port.
//
//   Optional build macro FPALL_ISSUE_STATS_EN adds two free-running 32-bit
//   counters: stat_issued (accepted ops) and stat_stall (cycles with
//   in_valid & ~in_ready). Without the macro these ports do not exist.
//
//   Parameters: LAT (datapath latency, posedges), FIFO_DEPTH (power of 2,
//   >=2), TAG_W (user tag width).
// ---------------------------------------------------------------------------
package fpall_pkg;
  typedef enum logic [1:0] {
    FMT_FP32 = 2'd0,
    FMT_FP16 = 2'd1,  // two bf16 lanes packed in 32 bits
    FMT_FP8  = 2'd2,
    FMT_RSVD = 2'd3
  } fp_fmt_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MIN = 3'd3,
    OP_MAX = 3'd4,
    OP_CMP = 3'd5,
    OP_CVT = 3'd6,
    OP_MOV = 3'd7
  } fp_op_e;
endpackage

module fpall_issue_ctrl
  import fpall_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  fp_op_e           in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output fp_fmt_e          fpu_fmt,
  output fp_op_e           fpu_opcode,
  output logic [31:0]      fpu_x,
  output logic [31:0]      fpu_y,
  input  logic [31:0]      fpu_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef FPALL_ISSUE_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Wide enough to hold FIFO_DEPTH plus every pipeline slot without wrap.
  localparam int CW    = $clog2(FIFO_DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]   vld_pipe;
  logic [TAG_W-1:0] tag_pipe [LAT];
  logic [31:0]      r_mem    [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem  [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    credits;
  logic             accept;
  logic             push;
  logic             pop;

  // Every op in the datapath already owns a FIFO slot, so the FIFO can
  // never overflow when the datapath delivers its result.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(vld_pipe[i]);
    end
  end

  assign credits   = CW'(FIFO_DEPTH) - CW'(fifo_count) - inflight;
  assign in_ready  = (credits != '0) & ~rst;
  assign accept    = in_valid & in_ready;
  assign push      = vld_pipe[LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_r     = r_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];
  assign busy      = (|vld_pipe) | out_valid;

  // Control state. fpu_* only move on accept so the datapath sees stable
  // operands between ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fpu_fmt    <= FMT_FP32;
      fpu_opcode <= OP_ADD;
      fpu_x      <= '0;
      fpu_y      <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      if (accept) begin
        fpu_fmt    <= in_fmt;
        fpu_opcode <= in_op;
        fpu_x      <= in_x;
        fpu_y      <= in_y;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Data storage needs no reset: validity lives in vld_pipe / fifo_count.
  // The rst guard keeps a dropped in-flight op from landing in the FIFO.
  always_ff @(posedge clk) begin
    if (accept) tag_pipe[0] <= in_tag;
    for (int i = 1; i < LAT; i++) begin
      tag_pipe[i] <= tag_pipe[i-1];
    end
    if (push && !rst) begin
      r_mem[wr_ptr]   <= fpu_r;
      tag_mem[wr_ptr] <= tag_pipe[LAT-1];
    end
  end

`ifdef FPALL_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept)               stat_issued <= stat_issued + 32'd1;
      if (in_valid & ~in_ready) stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpall_issue_ctrl
//   Bench for fpall_issue_ctrl. A stand-in datapath with LAT-1 register
//   stages produces fpu_r. The reference model is a queue of accepted ops:
//   each op has a result, a tag and the step at which it becomes visible.
//   Expected in_ready is "fewer than FIFO_DEPTH ops outstanding". busy is
//   "any op outstanding". Expected out_valid is "the oldest op has reached
//   its visible step".
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpall_issue_ctrl;
  import fpall_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int W     = 32 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  fp_fmt_e          in_fmt = FMT_FP32;
  fp_op_e           in_op = OP_ADD;
  logic [31:0]      in_x = '0;
  logic [31:0]      in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  fp_fmt_e          fpu_fmt;
  fp_op_e           fpu_opcode;
  logic [31:0]      fpu_x;
  logic [31:0]      fpu_y;
  logic [31:0]      fpu_r;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef FPALL_ISSUE_STATS_EN
  logic [31:0]      stat_issued;
  logic [31:0]      stat_stall;
`endif

  fpall_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .fpu_fmt(fpu_fmt), .fpu_opcode(fpu_opcode), .fpu_x(fpu_x), .fpu_y(fpu_y),
    .fpu_r(fpu_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
    .busy(busy)
`ifdef FPALL_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Stand-in datapath. A few bf16x2 adds are tabulated with real results;
  // everything else gets an arbitrary but operand-dependent mix.
  function automatic logic [31:0] dp_fn(input fp_fmt_e f, input fp_op_e o,
                                        input logic [31:0] x, input logic [31:0] y);
    if (f == FMT_FP16 && o == OP_ADD) begin
      if (x == 32'h3F80_3F80 && y == 32'h3F80_3F80) return 32'h4000_4000;
      if (x == 32'h3FC0_3FC0 && y == 32'hBFA0_BFA0) return 32'h3E80_3E80;
      if (x == 32'h4000_4000 && y == 32'h4000_4000) return 32'h4080_4080;
      if (x == 32'h3F80_3F80 && y == 32'hBF80_BF80) return 32'h0000_0000;
    end
    return (x ^ {y[15:0], y[31:16]}) + {27'd0, o, f};
  endfunction

  logic [31:0] dp_q;
  always @(posedge clk) dp_q <= dp_fn(fpu_fmt, fpu_opcode, fpu_x, fpu_y);
  assign fpu_r = dp_q;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // {result, tag} of outstanding ops, issue order
  int           exp_t_q[$]; // step at which each becomes visible
  logic [31:0]  got_r_q[$];
  logic [TAG_W-1:0] got_tag_q[$];
  int           got_t_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int step_no = 0;
  bit last_accept = 1'b0;
  int last_acc_step = 0;
  int m_issued = 0;
  int m_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, step_no, act, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model past the edge.
  task automatic step();
    bit exp_rdy, exp_ov, acc, pop;
    acc = 1'b0;
    pop = 1'b0;
    exp_rdy = 1'b0;
    @(negedge clk);
    if (rst) begin
      chk("in_ready_in_rst", in_ready, 0);
    end else begin
      exp_rdy = (exp_q.size() < DEPTH);
      exp_ov  = (exp_q.size() != 0) && (step_no >= exp_t_q[0]);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      chk("busy", busy, exp_q.size() != 0);
      if (exp_ov) begin
        chk("out_r", out_r, exp_q[0][W-1:TAG_W]);
        chk("out_tag", out_tag, exp_q[0][TAG_W-1:0]);
      end
`ifdef FPALL_ISSUE_STATS_EN
      chk("stat_issued", stat_issued, m_issued);
      chk("stat_stall", stat_stall, m_stall);
`endif
      acc = in_valid && exp_rdy;
      pop = exp_ov && out_ready;
      if (pop) begin
        got_r_q.push_back(out_r);
        got_tag_q.push_back(out_tag);
        got_t_q.push_back(step_no);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_t_q.delete();
      m_issued = 0;
      m_stall = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back({dp_fn(in_fmt, in_op, in_x, in_y), in_tag});
        // accepted at edge step_no, pushed at edge step_no+LAT,
        // seen at the next mid-cycle check
        exp_t_q.push_back(step_no + LAT + 1);
        m_issued++;
        last_acc_step = step_no;
      end
      if (in_valid && !exp_rdy) m_stall++;
    end
    last_accept = acc;
    step_no++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_op();
    in_fmt = fp_fmt_e'(2'($urandom_range(0, 3)));
    in_op  = fp_op_e'(3'($urandom_range(0, 7)));
    in_x   = $urandom;
    in_y   = $urandom;
    in_tag = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  // Hold in_valid with a fresh random op after each accept; out_ready low
  // for the first 'low' steps.
  task automatic run_ops(input int n, input int low, output int acc_low, output int steps);
    int sent = 0;
    int s = 0;
    acc_low = 0;
    rand_op();
    in_valid = 1'b1;
    while (sent < n && s < 300) begin
      out_ready = (s >= low);
      step();
      s++;
      if (last_accept) begin
        sent++;
        if (!out_ready) acc_low++;
        if (sent < n) rand_op();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    steps = s;
    chk("issue_timeout", sent, n);
    drain();
  endtask

  task automatic send(input fp_fmt_e f, input fp_op_e o, input logic [31:0] x,
                      input logic [31:0] y, input logic [TAG_W-1:0] t);
    int k = 0;
    in_fmt = f; in_op = o; in_x = x; in_y = y; in_tag = t;
    in_valid = 1'b1;
    do begin
      step();
      k++;
    end while (!last_accept && k < 50);
    chk("send_timeout", last_accept, 1);
    in_valid = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    fp_fmt_e          fmt;
    fp_op_e           op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [31:0]      r;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int a, st, k;
    tbl[0] = '{FMT_FP16, OP_ADD, 32'h3F80_3F80, 32'h3F80_3F80, 4'd5, 32'h4000_4000};
    tbl[1] = '{FMT_FP16, OP_ADD, 32'h3F80_3F80, 32'h3F80_3F80, 4'd1, 32'h4000_4000};
    tbl[2] = '{FMT_FP16, OP_ADD, 32'h3FC0_3FC0, 32'hBFA0_BFA0, 4'd2, 32'h3E80_3E80};
    tbl[3] = '{FMT_FP16, OP_ADD, 32'h4000_4000, 32'h4000_4000, 4'd3, 32'h4080_4080};
    tbl[4] = '{FMT_FP16, OP_ADD, 32'h3F80_3F80, 32'hBF80_BF80, 4'd4, 32'h0000_0000};

    do_reset(2);
    step();
    chk("rst_fpu_x", fpu_x, 0);
    chk("rst_fpu_y", fpu_y, 0);
    chk("rst_fpu_fmt", fpu_fmt, 0);
    chk("rst_fpu_op", fpu_opcode, 0);

    // 1: single FP16 add, latency and tag
    out_ready = 1'b1;
    got_r_q.delete(); got_tag_q.delete(); got_t_q.delete();
    send(tbl[0].fmt, tbl[0].op, tbl[0].x, tbl[0].y, tbl[0].tag);
    a = last_acc_step;
    drain();
    chk("t1_count", got_r_q.size(), 1);
    if (got_r_q.size() == 1) begin
      chk("t1_r", got_r_q[0], tbl[0].r);
      chk("t1_tag", got_tag_q[0], tbl[0].tag);
      chk("t1_latency", got_t_q[0] - a - 1, LAT);
    end

    // 2: table back-to-back, one accept per step, in-order results
    got_r_q.delete(); got_tag_q.delete(); got_t_q.delete();
    st = step_no;
    for (int i = 1; i < 5; i++) begin
      in_fmt = tbl[i].fmt; in_op = tbl[i].op; in_x = tbl[i].x; in_y = tbl[i].y;
      in_tag = tbl[i].tag; in_valid = 1'b1;
      k = 0;
      do begin step(); k++; end while (!last_accept && k < 20);
    end
    in_valid = 1'b0;
    chk("t2_b2b_steps", step_no - st, 4);
    drain();
    chk("t2_count", got_r_q.size(), 4);
    for (int i = 0; i < 4 && i < got_r_q.size(); i++) begin
      chk("t2_r", got_r_q[i], tbl[i+1].r);
      chk("t2_tag", got_tag_q[i], tbl[i+1].tag);
      if (i > 0) chk("t2_one_per_cycle", got_t_q[i] - got_t_q[i-1], 1);
    end

    // 3: consumer stalled -> exactly DEPTH accepts, then drain in order
    run_ops(5, 8, a, st);
    chk("t3_accepts_while_stalled", a, DEPTH);

    // 4: accept + pop every cycle with full credits
    run_ops(10, 0, a, st);
    chk("t4_no_stall_steps", st, 10);

    // 5: reset with two ops in flight
    out_ready = 1'b1;
    rand_op();
    in_valid = 1'b1;
    k = 0;
    do begin step(); k++; end while (!last_accept && k < 20);
    rand_op();
    step();
    chk("t5_second_accept", last_accept, 1);
    in_valid = 1'b0;
    got_r_q.delete(); got_tag_q.delete(); got_t_q.delete();
    do_reset(1);
    for (int i = 0; i < 5; i++) step();
    chk("t5_dropped", got_r_q.size(), 0);
    send(FMT_FP16, OP_ADD, 32'h3FC0_3FC0, 32'hBFA0_BFA0, 4'd9);
    drain();
    chk("t5_count", got_r_q.size(), 1);
    if (got_r_q.size() == 1) begin
      chk("t5_r", got_r_q[0], 32'h3E80_3E80);
      chk("t5_tag", got_tag_q[0], 4'd9);
    end

    // 6: six ops through a four-cycle consumer stall
    do_reset(1);
    run_ops(6, 4, a, st);
`ifdef FPALL_ISSUE_STATS_EN
    chk("t6_stat_issued", stat_issued, 6);
    chk("t6_stat_stall", stat_stall, m_stall);
`endif

    // random traffic with one mid-run reset
    for (int s = 0; s < 600; s++) begin
      if (s == 300) do_reset(1);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        rand_op();
        in_valid = 1'b1;
      end
      step();
      if (last_accept) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout step=%0d", step_no);
    $fatal(1);
  end

endmodule
